// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and sizing helper for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIVU = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider sharing one hi:lo register pair.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_nx_o,
  output logic [WIDTH-1:0] lo_nx_o
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic             div_q, div_d;
  logic [WIDTH:0]   sum, rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // One iteration: mul adds B into hi when lo[0] set then shifts right;
  // div shifts remainder left and subtracts B when it fits (quotient bit into lo).
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    diff    = rem_sh[WIDTH-1:0] - b_q;
    ge      = (rem_sh >= {1'b0, b_q});
    hi_nx_o = '0;
    lo_nx_o = '0;
    if (div_q) begin
      hi_nx_o = ge ? diff : rem_sh[WIDTH-1:0];
      lo_nx_o = {lo_q[WIDTH-2:0], ge};
    end else begin
      {hi_nx_o, lo_nx_o} = {sum, lo_q[WIDTH-1:1]};
    end
  end

  // Next-state selection for load / step.
  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    div_d = div_q;
    if (load_i) begin
      cnt_d = CW'(WIDTH);
      hi_d  = '0;
      lo_d  = a_i;
      b_d   = b_i;
      div_d = div_i;
    end else if (step_i) begin
      cnt_d = cnt_q - 1'b1;
      hi_d  = hi_nx_o;
      lo_d  = lo_nx_o;
    end
  end

  // Iteration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      div_q <= div_d;
    end
  end

  assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: FSM, single-cycle datapath, flags and result registers.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [3:0]       ALUCon,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Zero,
  output logic             Overflow,
  output logic             DivByZero,
  output logic             Error,
  output logic             Busy,
  output logic             Done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, resh_q, resh_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, dbz_q, dbz_d, err_q, err_d;

  logic [WIDTH-1:0] sc_res, sc_hi, add_r, sub_r;
  logic             sc_ovf, sc_dbz, sc_err, iter_op;
  logic             it_load, it_step, it_last;
  logic [WIDTH-1:0] it_hi, it_lo;

  assign add_r   = DataA + DataB;
  assign sub_r   = DataA - DataB;
  assign iter_op = (ALUCon == OP_MUL) || ((ALUCon == OP_DIVU) && (DataB != '0));

  // Single-cycle result and flags straight from the inputs.
  always_comb begin
    sc_res = '0;
    sc_hi  = '0;
    sc_ovf = 1'b0;
    sc_dbz = 1'b0;
    sc_err = 1'b0;
    case (ALUCon)
      OP_ADD: begin
        sc_res = add_r;
        sc_ovf = (DataA[WIDTH-1] == DataB[WIDTH-1]) && (add_r[WIDTH-1] != DataA[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_r;
        sc_ovf = (DataA[WIDTH-1] != DataB[WIDTH-1]) && (sub_r[WIDTH-1] != DataA[WIDTH-1]);
      end
      OP_MUL: ;
      OP_DIVU: begin
        sc_res = '1;
        sc_hi  = DataA;
        sc_dbz = 1'b1;
      end
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(DataA) < $signed(DataB))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (DataA < DataB)};
      OP_AND:  sc_res = DataA & DataB;
      OP_OR:   sc_res = DataA | DataB;
      OP_XOR:  sc_res = DataA ^ DataB;
      OP_NOR:  sc_res = ~(DataA | DataB);
      default: sc_err = 1'b1;
    endcase
  end

  // FSM next state, iterator control and output-register updates.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    resh_d  = resh_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    err_d   = err_q;
    it_load = 1'b0;
    it_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          ovf_d = 1'b0;
          dbz_d = 1'b0;
          err_d = 1'b0;
          if (iter_op) begin
            it_load = 1'b1;
            state_d = RUN;
          end else begin
            res_d   = sc_res;
            resh_d  = sc_hi;
            zero_d  = (sc_res == '0);
            ovf_d   = sc_ovf;
            dbz_d   = sc_dbz;
            err_d   = sc_err;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        it_step = 1'b1;
        // Final step's values are captured straight from the step logic so
        // outputs only ever show the completed result.
        if (it_last) begin
          res_d   = it_lo;
          resh_d  = it_hi;
          zero_d  = (it_lo == '0);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      resh_q  <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      resh_q  <= resh_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
      err_q   <= err_d;
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (it_load),
    .step_i  (it_step),
    .div_i   (ALUCon == OP_DIVU),
    .a_i     (DataA),
    .b_i     (DataB),
    .last_o  (it_last),
    .hi_nx_o (it_hi),
    .lo_nx_o (it_lo)
  );

  assign Result    = res_q;
  assign ResultHi  = resh_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;
  assign DivByZero = dbz_q;
  assign Error     = err_q;
  assign Busy      = (state_q != IDLE);
  assign Done      = (state_q == DONE);

endmodule
